// File: rtl/cgra_kernel_ctrl.sv
// cgra_kernel_ctrl: kernel execution controller for a CGRA tile.
// Turns the software start level into a one-shot trigger and latches the
// kernel length and iteration count. It then steps the shared instruction-ROM
// address through every iteration, drains the PE pipeline, and holds Done
// until software drops the start level.
//
// Handshake: Stall is a "not ready" from the BRAM port. A fetch happens in a
// cycle exactly when Inst_Rom_En is high (RUN and !Stall). A stalled RUN cycle
// holds address, iteration count and state unchanged.
module cgra_kernel_ctrl #(
  parameter int IADDR_WIDTH = 8,
  parameter int ITER_WIDTH  = 16,
  parameter int PIPE_DEPTH  = 2   // legal range 1..15
) (
  input  logic                   Clk,
  input  logic                   Resetn,
  input  logic                   Computation_Start,
  input  logic [IADDR_WIDTH-1:0] Kernel_Len,
  input  logic [ITER_WIDTH-1:0]  Iter_Num,
  input  logic                   Stall,
  output logic [IADDR_WIDTH-1:0] Inst_Rom_Addr,
  output logic                   Inst_Rom_En,
  output logic [ITER_WIDTH-1:0]  Iter_Cnt,
  output logic                   PE_Array_Busy,
  output logic                   Computation_Done,
  output logic [1:0]             State_Dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0]             DRAIN_INIT = 4'(PIPE_DEPTH - 1);
  localparam logic [3:0]             DRAIN_ONE  = 4'd1;
  localparam logic [IADDR_WIDTH-1:0] ADDR_ONE   = IADDR_WIDTH'(1);
  localparam logic [ITER_WIDTH-1:0]  ITER_ONE   = ITER_WIDTH'(1);

  state_e                 state_q, state_d;
  logic                   start_q;
  logic [IADDR_WIDTH-1:0] len_q, len_d;
  logic [ITER_WIDTH-1:0]  num_q, num_d;
  logic [IADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ITER_WIDTH-1:0]  iter_q, iter_d;
  logic [3:0]             drain_q, drain_d;
  logic                   trigger;

  // A start level that was low last cycle and is high now launches a run.
  assign trigger = Computation_Start & ~start_q;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      len_q   <= '0;
      num_q   <= '0;
      addr_q  <= '0;
      iter_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= Computation_Start;
      len_q   <= len_d;
      num_q   <= num_d;
      addr_q  <= addr_d;
      iter_q  <= iter_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic: sequencing of address, iteration count and drain timer.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    num_d   = num_q;
    addr_d  = addr_q;
    iter_d  = iter_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          len_d   = Kernel_Len;
          num_d   = Iter_Num;
          addr_d  = '0;
          iter_d  = '0;
          state_d = (Iter_Num == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!Stall) begin
          // Wrap only via the length compare so a full-range kernel is legal.
          if (addr_q != len_q) begin
            addr_d = addr_q + ADDR_ONE;
          end else begin
            addr_d = '0;
            iter_d = iter_q + ITER_ONE;
            if (iter_q == num_q - ITER_ONE) begin
              state_d = DRAIN;
              drain_d = DRAIN_INIT;
            end
          end
        end
      end
      DRAIN: begin
        // Stall is irrelevant here: no fetches are issued while draining.
        if (drain_q == '0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - DRAIN_ONE;
        end
      end
      DONE: begin
        if (!Computation_Start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Inst_Rom_Addr    = addr_q;
  assign Iter_Cnt         = iter_q;
  assign Inst_Rom_En      = (state_q == RUN) && !Stall;
  assign PE_Array_Busy    = (state_q == RUN) || (state_q == DRAIN);
  assign Computation_Done = (state_q == DONE);
  assign State_Dbg        = state_q;

endmodule

// File: tb/tb_cgra_kernel_ctrl.sv
// Bench for cgra_kernel_ctrl: the driver issues kernel runs and pushes the
// expected fetch stream, Done timing and Done release into queues; a monitor
// on the falling edge pops and compares whenever the DUT presents an event.
module tb_cgra_kernel_ctrl;

  localparam int IAW = 8;
  localparam int ITW = 16;
  localparam int PD  = 2;

  // ---------------- clock / reset ----------------
  logic           Clk = 1'b0;
  logic           Resetn = 1'b0;
  logic           Computation_Start = 1'b0;
  logic [IAW-1:0] Kernel_Len = '0;
  logic [ITW-1:0] Iter_Num = '0;
  logic           Stall = 1'b0;
  logic [IAW-1:0] Inst_Rom_Addr;
  logic           Inst_Rom_En;
  logic [ITW-1:0] Iter_Cnt;
  logic           PE_Array_Busy;
  logic           Computation_Done;
  logic [1:0]     State_Dbg;

  always #5 Clk = ~Clk;

  cgra_kernel_ctrl #(
    .IADDR_WIDTH(IAW),
    .ITER_WIDTH (ITW),
    .PIPE_DEPTH (PD)
  ) dut (
    .Clk              (Clk),
    .Resetn           (Resetn),
    .Computation_Start(Computation_Start),
    .Kernel_Len       (Kernel_Len),
    .Iter_Num         (Iter_Num),
    .Stall            (Stall),
    .Inst_Rom_Addr    (Inst_Rom_Addr),
    .Inst_Rom_En      (Inst_Rom_En),
    .Iter_Cnt         (Iter_Cnt),
    .PE_Array_Busy    (PE_Array_Busy),
    .Computation_Done (Computation_Done),
    .State_Dbg        (State_Dbg)
  );

  // Cycle c is the period after the c-th rising edge.
  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge Clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !Resetn;
  end

  // ---------------- scoreboard ----------------
  logic [23:0] fetch_q[$];   // {iteration, address} per expected fetch
  logic [63:0] done_q[$];    // {done cycle, final Iter_Cnt, busy cycles}
  logic [31:0] fall_q[$];    // cycle in which Done must be low again

  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  logic prev_done = 1'b0;

  // Monitor: compare every DUT event against the head of its queue.
  always @(negedge Clk) begin
    logic [23:0] ef;
    logic [63:0] ed;
    logic [31:0] el;
    if (rst_seen) begin
      checks++;
      if ({Inst_Rom_Addr, Iter_Cnt, Inst_Rom_En, PE_Array_Busy, Computation_Done} != '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got addr=%0d iter=%0d en=%0b busy=%0b done=%0b want all 0",
                 cyc, Inst_Rom_Addr, Iter_Cnt, Inst_Rom_En, PE_Array_Busy, Computation_Done);
      end
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (Inst_Rom_En === 1'b1) begin
        checks++;
        if (fetch_q.size() == 0) begin
          errors++;
          $display("FAIL fetch cyc=%0d got iter=%0d addr=%0d want no fetch", cyc, Iter_Cnt, Inst_Rom_Addr);
        end else begin
          ef = fetch_q.pop_front();
          if ({Iter_Cnt, Inst_Rom_Addr} !== ef) begin
            errors++;
            $display("FAIL fetch cyc=%0d got iter=%0d addr=%0d want iter=%0d addr=%0d",
                     cyc, Iter_Cnt, Inst_Rom_Addr, ef[23:8], ef[7:0]);
          end
        end
      end
      if (PE_Array_Busy === 1'b1) busy_cnt++;
      if (Computation_Done === 1'b1 && !prev_done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_rise cyc=%0d got unexpected Done want none", cyc);
        end else begin
          ed = done_q.pop_front();
          if ({cyc[31:0], Iter_Cnt, busy_cnt[15:0]} !== ed) begin
            errors++;
            $display("FAIL done_rise got cyc=%0d iter=%0d busy=%0d want cyc=%0d iter=%0d busy=%0d",
                     cyc, Iter_Cnt, busy_cnt, ed[63:32], ed[31:16], ed[15:0]);
          end
        end
        busy_cnt = 0;
      end
      if (Computation_Done === 1'b0 && prev_done) begin
        checks++;
        if (fall_q.size() == 0) begin
          errors++;
          $display("FAIL done_fall cyc=%0d got unexpected fall want none", cyc);
        end else begin
          el = fall_q.pop_front();
          if (cyc[31:0] !== el) begin
            errors++;
            $display("FAIL done_fall got cyc=%0d want cyc=%0d", cyc, el);
          end
        end
      end
      prev_done = (Computation_Done === 1'b1);
    end
  end

  // ---------------- driver ----------------
  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  // mode 0: hold Start through Done for 'hold' extra cycles, then drop it
  // mode 1: drop Start right after the trigger
  // mode 2: drop then re-raise Start mid-run (a re-trigger that must be ignored)
  // rst_at >= 0: pull Resetn low in that RUN cycle and abandon the run
  task automatic run_kernel(input int L, input int N, input int mode, input int hold,
                            input int rst_at, input logic [31:0] mask, input int pct);
    int total, fetched, i, t0, done_cyc, busy, fall_cyc;
    logic aborted;
    Kernel_Len        = L[IAW-1:0];
    Iter_Num          = N[ITW-1:0];
    Computation_Start = 1'b1;
    Stall             = 1'($urandom_range(1));
    for (int it = 0; it < N; it++)
      for (int a = 0; a <= L; a++)
        fetch_q.push_back({it[15:0], a[7:0]});
    next_cycle();
    t0 = cyc;
    // Inputs may change freely once latched.
    Kernel_Len = IAW'($urandom);
    Iter_Num   = ITW'($urandom);
    total   = (L + 1) * N;
    fetched = 0;
    i       = 0;
    aborted = 1'b0;
    while (fetched < total) begin
      Stall = ((i < 32) && mask[i]) || ($urandom_range(99) < pct);
      if (mode != 0 && i == 0) Computation_Start = 1'b0;
      if (mode == 2 && i == 1) Computation_Start = 1'b1;
      if (i == rst_at) begin
        Resetn            = 1'b0;
        Computation_Start = 1'b0;
      end
      if (!Stall) fetched++;
      i++;
      next_cycle();
      if (!Resetn) begin
        fetch_q.delete();
        Resetn  = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      next_cycle();
      return;
    end
    done_cyc = (N == 0) ? t0 : t0 + i + PD;
    busy     = (N == 0) ? 0 : i + PD;
    done_q.push_back({done_cyc[31:0], N[15:0], busy[15:0]});
    if (Computation_Start == 1'b0) begin
      fall_cyc = done_cyc + 1;
    end else begin
      while (cyc < done_cyc + hold) begin
        Stall = 1'($urandom_range(1));
        next_cycle();
      end
      Computation_Start = 1'b0;
      fall_cyc = done_cyc + hold + 1;
    end
    fall_q.push_back(fall_cyc[31:0]);
    while (cyc < fall_cyc) begin
      Stall = 1'($urandom_range(1));
      next_cycle();
    end
  endtask

  // ---------------- stimulus and final report ----------------
  initial begin
    Resetn = 1'b0;
    repeat (3) next_cycle();
    Resetn = 1'b1;
    repeat (2) next_cycle();

    run_kernel(3, 2, 0, 4, -1, 32'h0, 0);        // basic two-iteration run
    run_kernel(3, 2, 0, 2, -1, 32'hC, 0);        // stall on the third/fourth RUN cycles
    run_kernel(5, 0, 0, 3, -1, 32'h0, 0);        // zero iterations: straight to Done
    run_kernel(0, 3, 0, 5, -1, 32'h0, 0);        // single-instruction kernel, Start held
    run_kernel(0, 3, 0, 0, -1, 32'h0, 30);       // next rising edge starts fresh
    run_kernel(3, 2, 0, 0, 2, 32'h0, 0);         // reset at address 2
    run_kernel(3, 1, 0, 0, 3, 32'h8, 0);         // reset while stalled on the last address
    run_kernel(255, 1, 0, 1, -1, 32'h0, 0);      // full-range address sweep
    run_kernel(2, 3, 1, 0, -1, 32'h0, 25);       // Start dropped early
    run_kernel(2, 2, 2, 1, -1, 32'h0, 25);       // ignored re-trigger mid-run
    run_kernel(1, 2, 0, 0, -1, 32'h2, 0);        // stall on the last address of an iteration

    for (int r = 0; r < 30; r++) begin
      int l, n, m, ra;
      l  = $urandom_range(15);
      n  = $urandom_range(4);
      m  = $urandom_range(2);
      ra = -1;
      if (n > 0 && $urandom_range(9) == 0) ra = $urandom_range((l + 1) * n - 1);
      run_kernel(l, n, m, $urandom_range(3), ra, $urandom, $urandom_range(40));
    end

    repeat (5) next_cycle();
    checks++;
    if (fetch_q.size() != 0) begin
      errors++;
      $display("FAIL fetch_drain got %0d pending want 0", fetch_q.size());
    end
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL done_drain got %0d pending want 0", done_q.size());
    end
    checks++;
    if (fall_q.size() != 0) begin
      errors++;
      $display("FAIL fall_drain got %0d pending want 0", fall_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
